// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two valid/ready requesters share one Mux2 datapath.
// A round-robin grant drives the mux select, and the chosen beat is captured in
// a 1-entry output register. The output register loads when it is empty or
// being drained.
// Optional packet mode: define MUX2_RR_ARBITER_LAST_EN. This adds the
// I0_last/I1_last/O_last ports. It also holds the grant on one source until
// that source sends its last beat.
module mux2_rr_arbiter #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             I0_valid,
  input  logic [WIDTH-1:0] I0_data,
  output logic             I0_ready,
  input  logic             I1_valid,
  input  logic [WIDTH-1:0] I1_data,
  output logic             I1_ready,
  output logic             O_valid,
  output logic [WIDTH-1:0] O_data,
  output logic             O_sel,
  input  logic             O_ready
`ifdef MUX2_RR_ARBITER_LAST_EN
  ,
  input  logic             I0_last,
  input  logic             I1_last,
  output logic             O_last
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t state;
  logic   ptr;        // source that won the last arbitration; the other wins the next tie
  logic   load;       // output register can take a beat this cycle
  logic   grant;      // mux select / granted source
  logic   grant_vld;  // granted source actually has a beat
  logic   accept;     // a beat moves into the output register this cycle
  logic   acc_last;   // accepted beat ends its packet

  // Grant selection, mux select and ready generation
  always_comb begin
    load      = ~O_valid | O_ready;
    grant     = 1'b0;
    grant_vld = 1'b0;
    case (state)
      LOCK0: begin
        grant     = 1'b0;
        grant_vld = I0_valid;
      end
      LOCK1: begin
        grant     = 1'b1;
        grant_vld = I1_valid;
      end
      default: begin
        grant_vld = I0_valid | I1_valid;
        if (I0_valid & I1_valid) grant = ~ptr;
        else                     grant = I1_valid;
      end
    endcase
    // Readys are forced low while reset is held
    accept   = ASYNCRESETN & load & grant_vld;
    I0_ready = accept & ~grant;
    I1_ready = accept & grant;
  end

`ifdef MUX2_RR_ARBITER_LAST_EN
  assign acc_last = grant ? I1_last : I0_last;

  // Packet lock: stay on the granted source until its last beat is accepted
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state <= IDLE;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (!acc_last) state <= grant ? LOCK1 : LOCK0;
        end
        default: begin
          if (acc_last) state <= IDLE;
        end
      endcase
    end
  end
`else
  // Every beat is its own packet, so arbitration never locks
  assign acc_last = 1'b1;
  assign state    = IDLE;
`endif

  // Output register and round-robin pointer
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      O_valid <= 1'b0;
      O_data  <= '0;
      O_sel   <= 1'b0;
      ptr     <= 1'b1;
`ifdef MUX2_RR_ARBITER_LAST_EN
      O_last  <= 1'b0;
`endif
    end else if (accept) begin
      O_data  <= grant ? I1_data : I0_data;
      O_sel   <= grant;
      O_valid <= 1'b1;
      if (acc_last) ptr <= grant;
`ifdef MUX2_RR_ARBITER_LAST_EN
      O_last  <= acc_last;
`endif
    end else if (O_ready) begin
      O_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter (WIDTH=8).
// The stimulus process drives one cycle at a time and checks the readys.
// It also pushes the expected output beat into a queue.
// The monitor pops one beat from the queue for each output handshake.
module tb_mux2_rr_arbiter;
  localparam int W = 8;
`ifdef MUX2_RR_ARBITER_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i0_valid = 1'b0, i1_valid = 1'b0;
  logic [W-1:0] i0_data = '0, i1_data = '0;
  logic         i0_last = 1'b0, i1_last = 1'b0;
  logic         i0_ready, i1_ready;
  logic         o_valid, o_sel, o_last;
  logic [W-1:0] o_data;
  logic         o_ready = 1'b0;

  mux2_rr_arbiter #(.WIDTH(W)) dut (
    .CLK(clk), .ASYNCRESETN(rst_n),
    .I0_valid(i0_valid), .I0_data(i0_data), .I0_ready(i0_ready),
    .I1_valid(i1_valid), .I1_data(i1_data), .I1_ready(i1_ready),
    .O_valid(o_valid), .O_data(o_data), .O_sel(o_sel), .O_ready(o_ready)
`ifdef MUX2_RR_ARBITER_LAST_EN
    , .I0_last(i0_last), .I1_last(i1_last), .O_last(o_last)
`endif
  );
`ifndef MUX2_RR_ARBITER_LAST_EN
  assign o_last = 1'b1;
`endif

  // posedges at 5, 15, ...; negedges at 10, 20, ...
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         sel;
    logic         last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model state: output occupancy, last packet winner, locked source (-1 = none)
  bit m_valid = 1'b0;
  int m_winner = 1;
  int m_lock = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_valid  = 1'b0;
    m_winner = 1;
    m_lock   = -1;
  endtask

  // One clock cycle of stimulus plus a model update for the upcoming edge
  task automatic step(input bit v0, input logic [W-1:0] d0, input bit l0,
                      input bit v1, input logic [W-1:0] d1, input bit l1,
                      input bit ordy);
    int g;
    bit can_load, acc, lst;
    @(negedge clk);
    i0_valid = v0; i0_data = d0; i0_last = l0;
    i1_valid = v1; i1_data = d1; i1_last = l1;
    o_ready  = ordy;
    #1;
    check("o_valid", {31'd0, o_valid}, {31'd0, m_valid});
    g = -1;
    if (m_lock == 0)      g = v0 ? 0 : -1;
    else if (m_lock == 1) g = v1 ? 1 : -1;
    else if (v0 && v1)    g = 1 - m_winner;
    else if (v0)          g = 0;
    else if (v1)          g = 1;
    can_load = !m_valid || ordy;
    acc = can_load && (g >= 0);
    check("i0_ready", {31'd0, i0_ready}, {31'd0, acc && g == 0});
    check("i1_ready", {31'd0, i1_ready}, {31'd0, acc && g == 1});
    if (acc) begin
      lst = LAST_EN ? ((g == 1) ? l1 : l0) : 1'b1;
      exp_q.push_back('{data: (g == 1) ? d1 : d0, sel: (g == 1), last: lst});
      m_valid = 1'b1;
      if (lst) m_winner = g;
      if (m_lock < 0 && !lst)      m_lock = g;
      else if (m_lock >= 0 && lst) m_lock = -1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
  endtask

  // Asynchronous reset pulse between edges while both sources are valid
  task automatic reset_pulse();
    @(negedge clk);
    i0_valid = 1'b1; i1_valid = 1'b1; o_ready = 1'b0;
    #1;
    check("pre_reset_o_valid", {31'd0, o_valid}, {31'd0, m_valid});
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_o_valid", {31'd0, o_valid}, 32'd0);
    check("rst_o_data", {24'd0, o_data}, 32'd0);
    check("rst_o_sel", {31'd0, o_sel}, 32'd0);
    check("rst_i0_ready", {31'd0, i0_ready}, 32'd0);
    check("rst_i1_ready", {31'd0, i1_ready}, 32'd0);
    i0_valid = 1'b0; i1_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: every output handshake must match the oldest expected beat
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected actual=data %0h sel %0d required=no beat", o_data, o_sel);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("out_data", {24'd0, o_data}, {24'd0, b.data});
          check("out_sel", {31'd0, o_sel}, {31'd0, b.sel});
          if (LAST_EN) check("out_last", {31'd0, o_last}, {31'd0, b.last});
        end
      end
    end
  end

  initial begin
    #1;
    check("init_o_valid", {31'd0, o_valid}, 32'd0);
    check("init_o_data", {24'd0, o_data}, 32'd0);
    check("init_o_sel", {31'd0, o_sel}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single source beat
    step(1, 8'hA5, 1, 0, 8'h00, 1, 1);
    step(0, 8'h00, 1, 0, 8'h00, 1, 0);

    // Reset pulse while the output register holds a beat
    reset_pulse();

    // Both valid after reset: alternating 0,1,0,1
    for (int i = 0; i < 4; i++) step(1, 8'h11, 1, 1, 8'h22, 1, 1);

    // Backpressure: hold 0x33 for 3 cycles, then a same-cycle reload
    step(1, 8'h33, 1, 0, 8'h00, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 8'h44, 1, 1, 8'h55, 1, 0);
    step(1, 8'h44, 1, 1, 8'h55, 1, 1);
    step(0, 8'h00, 1, 0, 8'h00, 1, 1);

`ifdef MUX2_RR_ARBITER_LAST_EN
    // Packet of 4 beats from I0 while I1 waits
    reset_pulse();
    for (int i = 1; i <= 4; i++) step(1, 8'(i), (i == 4), 1, 8'hB0, 1, 1);
    step(0, 8'h00, 1, 1, 8'hB1, 1, 1);
    step(0, 8'h00, 1, 0, 8'h00, 1, 1);

    // Reset in the middle of an I0 packet clears the lock
    step(1, 8'hC1, 0, 0, 8'h00, 0, 1);
    step(1, 8'hC2, 0, 0, 8'h00, 0, 1);
    reset_pulse();
    step(1, 8'hD0, 1, 1, 8'hE0, 1, 1);
    step(1, 8'hD1, 1, 1, 8'hE1, 1, 1);
    step(0, 8'h00, 1, 0, 8'h00, 1, 1);
`endif

    // Randomized traffic with random backpressure and packet boundaries
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) != 0));
    end

    // Drain, forcing any open packet to close
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 8'h00, 1, 1);
    step(1, 8'hF0, 1, 1, 8'hF1, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 8'h00, 1, 1);
    @(negedge clk);
    #3;
    check("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
